// File: rtl/uart_tx.sv
// 8N1 UART transmitter with a small power-of-two transmit FIFO.
// txd is a registered function of the FSM state, so it lags the state by one clock.
module uart_tx #(
    parameter int CLKS_PER_BIT = 217,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       txd,
    output logic       busy
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int AW    = $clog2(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t           state;
    logic [CNT_W-1:0] baud_cnt;
    logic [2:0]       bit_cnt;
    logic [7:0]       shift;
    logic [7:0]       mem [FIFO_DEPTH];
    logic [AW:0]      wptr;
    logic [AW:0]      rptr;
    logic             fifo_empty;
    logic             fifo_full;
    logic             push;
    logic             pop;
    logic             baud_end;

    // Extra pointer MSB distinguishes full from empty when the index bits match.
    assign fifo_empty = (wptr == rptr);
    assign fifo_full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign tx_ready   = !fifo_full;
    assign push       = tx_valid && !fifo_full;
    assign baud_end   = (baud_cnt == CNT_MAX);
    assign pop        = !fifo_empty && ((state == IDLE) || (state == STOP && baud_end));

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state    <= IDLE;
            txd      <= 1'b1;
            busy     <= 1'b0;
            wptr     <= '0;
            rptr     <= '0;
            baud_cnt <= '0;
            bit_cnt  <= '0;
        end else begin
            if (push) wptr <= wptr + 1'b1;
            if (pop)  rptr <= rptr + 1'b1;
            busy <= (state != IDLE) || !fifo_empty;
            case (state)
                START:   txd <= 1'b0;
                DATA:    txd <= shift[0];
                default: txd <= 1'b1;
            endcase

            if (state == IDLE) baud_cnt <= '0;
            else               baud_cnt <= baud_end ? '0 : baud_cnt + 1'b1;

            case (state)
                IDLE: begin
                    bit_cnt <= '0;
                    if (!fifo_empty) state <= START;
                end
                START: if (baud_end) state <= DATA;
                DATA: if (baud_end) begin
                    if (bit_cnt == 3'd7) state <= STOP;
                    else                 bit_cnt <= bit_cnt + 1'b1;
                end
                STOP: begin
                    bit_cnt <= '0;
                    if (baud_end) state <= fifo_empty ? IDLE : START;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Datapath: FIFO storage and shift register carry no reset.
    always_ff @(posedge clk) begin
        if (push && resetn) mem[wptr[AW-1:0]] <= tx_data;
        if (pop)
            shift <= mem[rptr[AW-1:0]];
        else if (state == DATA && baud_end)
            shift <= {1'b0, shift[7:1]};
    end

endmodule

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 217: clocks per UART bit (25 MHz / 115200 baud).
REQ-002 SHALL have parameter FIFO_DEPTH, default 4: transmit FIFO entries; power of two, >= 2.
REQ-003 SHALL have port clk  input  1  single system clock; all logic on rising edge.
REQ-004 SHALL have port resetn  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port tx_data  input  8  byte to transmit.
REQ-006 SHALL have port tx_valid  input  1  tx_data is valid this cycle.
REQ-007 SHALL have port tx_ready  output  1  FIFO can accept a byte this cycle.
REQ-008 SHALL have port txd  output  1  serial line; idle high; registered.
REQ-009 SHALL have port busy  output  1  frame in progress or FIFO non-empty.

Function
REQ-010 SHALL accept a byte on any rising edge where tx_valid && tx_ready, writing it to the FIFO tail.
REQ-011 SHALL drive tx_ready = !fifo_full, from registered state only, with no combinational path from tx_valid.
REQ-012 SHALL ignore tx_valid while tx_ready is low; the byte is neither stored nor lost-counted, and the producer holds it.
REQ-013 SHALL implement FSM states IDLE, START, DATA, STOP.
REQ-014 IDLE: txd=1; if FIFO non-empty, pop head into shift register, load bit counter 0, go to START.
REQ-015 START: txd=0 for exactly CLKS_PER_BIT cycles, then go to DATA.
REQ-016 DATA: txd = shift[0], LSB first; each bit held exactly CLKS_PER_BIT cycles; after bit 7, go to STOP.
REQ-017 STOP: txd=1 for exactly CLKS_PER_BIT cycles; then pop and go to START if FIFO non-empty (no idle gap), else go to IDLE.
REQ-018 Frame length SHALL be exactly 10*CLKS_PER_BIT cycles: 8N1, no parity.
REQ-019 Latency: byte accepted at edge N into an empty, idle block SHALL show txd=0 from edge N+2.
REQ-020 Baud counter SHALL count 0..CLKS_PER_BIT-1 and wrap, with width $clog2(CLKS_PER_BIT); no drift across back-to-back frames.
REQ-021 FIFO pointers SHALL be log2(FIFO_DEPTH)+1 bits, with full/empty from MSB compare; wrap-around SHALL be seamless.
REQ-022 Simultaneous push and pop: when not full, both SHALL occur and level is unchanged; when full, push is refused because tx_ready=0 and pop proceeds.
REQ-023 busy SHALL equal (state != IDLE) || !fifo_empty, registered.
REQ-024 A byte in the shift register SHALL NOT be altered by FIFO writes during its frame.

Reset
REQ-025 When resetn=0 at a rising edge, the block SHALL set: state IDLE, txd=1, FIFO emptied, tx_ready=1, busy=0, counters 0.
REQ-026 Reset mid-frame SHALL abort the frame: txd=1 from the next edge; queued bytes are discarded.
REQ-027 While resetn=0, the block SHALL accept no bytes regardless of tx_valid.
REQ-028 After resetn rises, the first accepted byte SHALL obey REQ-019 timing.

Verification
REQ-029 Single byte: push 0x34 -> txd = 0,0,0,1,0,1,1,0,0,1, each for 217 cycles (2170 cycles total); busy=0 one cycle after stop ends.
REQ-030 Back-to-back: push 0x34,0x35,0x2A,0x34,0x32 on consecutive cycles -> five contiguous frames with no idle gap; a loopback UART RX model decodes "45*42".
REQ-031 Backpressure: hold tx_valid high with 6 distinct bytes while idle -> first 5 accepted (1 popped + 4 queued); tx_ready=0 until the first stop bit completes; all 6 bytes transmitted in order.
REQ-032 Reset mid-frame: push 0x39,0x39; assert resetn=0 during bit 3 of the first byte -> txd=1 next edge; nothing further transmitted; tx_ready=1, busy=0.
REQ-033 Pointer wrap: stream 3*FIFO_DEPTH+1 bytes (0x30..0x3C) with random tx_valid gaps -> decoded stream identical and ordered; txd never glitches within a bit period.
REQ-034 Parameter: CLKS_PER_BIT=4 -> byte 0xFF gives txd low for 4 cycles, then high for 36 cycles.
